// File: rtl/nexys_starship_hazard_gen_if.sv
// Hazard generator bus: game control, timebase, shield status and break request.
// master drives the game-side inputs; slave is the generator itself.
interface nexys_starship_hazard_gen_if;
   logic       play_flag;
   logic       gameover_ctrl;
   logic       timer_clk;
   logic [3:0] shield_broken;
   logic [3:0] break_random;
   logic [3:0] random_hex;
   logic       q_HG_Idle;
   logic       q_HG_Cool;
   logic       q_HG_Select;
   logic       q_HG_Issue;

   modport master (
      output play_flag, gameover_ctrl, timer_clk, shield_broken,
      input  break_random, random_hex,
      input  q_HG_Idle, q_HG_Cool, q_HG_Select, q_HG_Issue
   );

   modport slave (
      input  play_flag, gameover_ctrl, timer_clk, shield_broken,
      output break_random, random_hex,
      output q_HG_Idle, q_HG_Cool, q_HG_Select, q_HG_Issue
   );
endinterface

// File: rtl/nexys_starship_hazard_gen.sv
// Starship hazard generator: picks an unbroken shield, requests a break, waits cooldown.
// Optional HAZARD_LEVELUP_EN shortens the cooldown every 4th acknowledged break.
module nexys_starship_hazard_gen #(
   parameter int         COOLDOWN_TICKS = 8,
   parameter int         MIN_COOLDOWN   = 2,
   parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
   input logic Clk,
   input logic Reset,
   nexys_starship_hazard_gen_if.slave hz
);

   localparam int CD_W = 16;
   localparam logic [CD_W-1:0] CD_BASE =
      (COOLDOWN_TICKS == 0) ? CD_W'(1) : CD_W'(COOLDOWN_TICKS);
   localparam logic [CD_W-1:0] CD_MIN =
      (MIN_COOLDOWN == 0) ? CD_W'(1) : CD_W'(MIN_COOLDOWN);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_COOL   = 2'd1;
   localparam logic [1:0] S_SELECT = 2'd2;
   localparam logic [1:0] S_ISSUE  = 2'd3;

   logic [1:0]      state;
   logic [7:0]      lfsr;
   logic            tmr_q;
   logic            tick;
   logic [CD_W-1:0] cnt;
   logic [CD_W-1:0] cd_cur;
   logic [1:0]      tgt;
   logic [3:0]      hex;
   logic [1:0]      pick;
   logic [1:0]      idx;
   logic            all_brk;
   logic            ack;

   assign tick    = hz.timer_clk & ~tmr_q;
   assign all_brk = &hz.shield_broken;
   assign ack     = (state == S_ISSUE) & ~hz.gameover_ctrl
                  & hz.shield_broken[tgt];

   // Nearest unbroken shield at or above the candidate, wrapping mod 4
   always_comb begin
      pick = lfsr[5:4];
      idx  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         idx = lfsr[5:4] + 2'(i);
         if (!hz.shield_broken[idx])
            pick = idx;
      end
   end

`ifdef HAZARD_LEVELUP_EN
   logic [1:0]      lvl;
   logic [CD_W-1:0] cd_reg;

   assign cd_cur = cd_reg;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         lvl    <= 2'd0;
         cd_reg <= CD_BASE;
      end else if (state == S_IDLE) begin
         cd_reg <= CD_BASE;
      end else if (ack) begin
         lvl <= lvl + 2'd1;
         if (lvl == 2'd3 && cd_reg > CD_MIN)
            cd_reg <= cd_reg - CD_W'(1);
      end
   end
`else
   assign cd_cur = CD_BASE;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         lfsr <= LFSR_SEED;
         tmr_q <= 1'b0;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         tmr_q <= hz.timer_clk;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= S_IDLE;
         cnt   <= CD_BASE;
         tgt   <= 2'd0;
         hex   <= 4'h1;
      end else if (hz.gameover_ctrl) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (hz.play_flag) begin
                  cnt   <= cd_cur;
                  state <= S_COOL;
               end
            end
            S_COOL: begin
               if (tick) begin
                  cnt <= cnt - CD_W'(1);
                  if (cnt <= CD_W'(1))
                     state <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (!all_brk) begin
                  tgt   <= pick;
                  hex   <= (lfsr[3:0] == 4'h0) ? 4'h1 : lfsr[3:0];
                  state <= S_ISSUE;
               end
            end
            default: begin
               if (ack) begin
                  cnt   <= cd_cur;
                  state <= S_COOL;
               end
            end
         endcase
      end
   end

   assign hz.break_random = (state == S_ISSUE) ? (4'b0001 << tgt) : 4'b0000;
   assign hz.random_hex   = hex;
   assign hz.q_HG_Idle    = (state == S_IDLE);
   assign hz.q_HG_Cool    = (state == S_COOL);
   assign hz.q_HG_Select  = (state == S_SELECT);
   assign hz.q_HG_Issue   = (state == S_ISSUE);

endmodule
